// File: rtl/cfo_derotator_if.sv
// Frequency-word and symbol-stream bundle for the CFO derotator.
// The master drives loads and samples; the slave returns derotated data.
interface cfo_derotator_if #(
  parameter int PHASE_ACC_BITS = 32,
  parameter int IQ_WIDTH       = 16
);
  logic                             freq_load;
  logic                             freq_add;
  logic signed [PHASE_ACC_BITS-1:0] freq_word_in;
  logic                             phase_clr;
  logic                             vld_in;
  logic signed [IQ_WIDTH-1:0]       i_in;
  logic signed [IQ_WIDTH-1:0]       q_in;
  logic                             vld_out;
  logic signed [IQ_WIDTH-1:0]       i_out;
  logic signed [IQ_WIDTH-1:0]       q_out;
  logic signed [PHASE_ACC_BITS-1:0] freq_word;
  logic        [PHASE_ACC_BITS-1:0] phase;
  logic                             loaded;

  modport master (
    output freq_load, freq_add, freq_word_in,
    output phase_clr, vld_in, i_in, q_in,
    input  vld_out, i_out, q_out,
    input  freq_word, phase, loaded
  );

  modport slave (
    input  freq_load, freq_add, freq_word_in,
    input  phase_clr, vld_in, i_in, q_in,
    output vld_out, i_out, q_out,
    output freq_word, phase, loaded
  );
endinterface

// File: rtl/cfo_derotator.sv
// NCO-driven derotator: holds the CFO word, steps phase per symbol and
// multiplies I/Q by exp(-j*phase) through a quarter-wave LUT, 4-clk latency.
module cfo_derotator #(
  parameter int PHASE_ACC_BITS = 32,
  parameter int IQ_WIDTH       = 16,
  parameter int LUT_ADDR_BITS  = 10,
  parameter int LUT_WIDTH      = 16
) (
  input  logic           clk,
  input  logic           rst_n,
  cfo_derotator_if.slave bus
);
  localparam int  PAB = PHASE_ACC_BITS;
  localparam int  LAB = LUT_ADDR_BITS;
  localparam int  IB  = LAB - 2;
  localparam int  N   = 1 << LAB;
  localparam int  N4  = N / 4;
  localparam int  PW  = IQ_WIDTH + LUT_WIDTH;
  localparam int  RND = 1 << (LUT_WIDTH - 2);
  localparam real PI  = 3.14159265358979323846;
  localparam real FS  = real'((1 << (LUT_WIDTH - 1)) - 1);

  localparam logic [IB:0] N4V = (IB + 1)'(N4);
  localparam logic signed [PW:0] HI =
    (PW + 1)'((1 << (IQ_WIDTH - 1)) - 1);
  localparam logic signed [PW:0] LO = ~HI;

  // First-quadrant sine, endpoints included so the mirror never wraps
  logic signed [LUT_WIDTH-1:0] rom [0:N4];

  for (genvar k = 0; k <= N4; k++) begin : g_rom
    localparam int V =
      $rtoi($floor($sin(2.0 * PI * k / N) * FS + 0.5));
    assign rom[k] = LUT_WIDTH'(V);
  end

  logic signed [PAB-1:0] fw_q, fw_d;
  logic        [PAB-1:0] ph_q, ph_d;
  logic                  ld_q, ld_d;

  always_comb begin
    fw_d = fw_q;
    ld_d = ld_q;
    ph_d = ph_q;
    if (bus.freq_load) begin
      fw_d = bus.freq_add ? fw_q + bus.freq_word_in
                          : bus.freq_word_in;
      ld_d = 1'b1;
    end
    // A word loaded this cycle already steers this symbol's step
    if (bus.phase_clr)
      ph_d = '0;
    else if (bus.vld_in)
      ph_d = ph_q + $unsigned(fw_d);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fw_q <= '0;
      ph_q <= '0;
      ld_q <= 1'b0;
    end else begin
      fw_q <= fw_d;
      ph_q <= ph_d;
      ld_q <= ld_d;
    end
  end

  logic                       v0_q, v1_q, v2_q, v3_q;
  logic signed [IQ_WIDTH-1:0] i0_q, q0_q, i1_q, q1_q;
  logic        [LAB-1:0]      a0_q;
  logic signed [LUT_WIDTH-1:0] c1_q, s1_q;
  logic signed [PW-1:0]       ic_q, qs_q, qc_q, is_q;
  logic signed [IQ_WIDTH-1:0] i3_q, q3_q;

  logic [1:0]                  qd;
  logic [IB-1:0]               idx;
  logic [IB:0]                 mi;
  logic signed [LUT_WIDTH-1:0] r_idx, r_mir;
  logic signed [LUT_WIDTH-1:0] cos_d, sin_d;

  always_comb begin
    qd    = a0_q[LAB-1 -: 2];
    idx   = a0_q[IB-1:0];
    mi    = N4V - {1'b0, idx};
    r_idx = rom[{1'b0, idx}];
    r_mir = rom[mi];
    cos_d = '0;
    sin_d = '0;
    unique case (qd)
      2'd0: begin cos_d =  r_mir; sin_d =  r_idx; end
      2'd1: begin cos_d = -r_idx; sin_d =  r_mir; end
      2'd2: begin cos_d = -r_mir; sin_d = -r_idx; end
      2'd3: begin cos_d =  r_idx; sin_d = -r_mir; end
      default: ;
    endcase
  end

  function automatic logic signed [IQ_WIDTH-1:0] sat(
    input logic signed [PW:0] x
  );
    if (x > HI)      return HI[IQ_WIDTH-1:0];
    else if (x < LO) return LO[IQ_WIDTH-1:0];
    else             return x[IQ_WIDTH-1:0];
  endfunction

  logic signed [PW:0] re_s, im_s, re_r, im_r;
  logic signed [PW:0] re_sh, im_sh;

  always_comb begin
    re_s  = ic_q + qs_q;
    im_s  = qc_q - is_q;
    re_r  = re_s + $signed((PW + 1)'(RND));
    im_r  = im_s + $signed((PW + 1)'(RND));
    re_sh = re_r >>> (LUT_WIDTH - 1);
    im_sh = im_r >>> (LUT_WIDTH - 1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v0_q <= 1'b0;
      v1_q <= 1'b0;
      v2_q <= 1'b0;
      v3_q <= 1'b0;
      i0_q <= '0;
      q0_q <= '0;
      a0_q <= '0;
      i1_q <= '0;
      q1_q <= '0;
      c1_q <= '0;
      s1_q <= '0;
      ic_q <= '0;
      qs_q <= '0;
      qc_q <= '0;
      is_q <= '0;
      i3_q <= '0;
      q3_q <= '0;
    end else begin
      v0_q <= bus.vld_in;
      i0_q <= bus.i_in;
      q0_q <= bus.q_in;
      a0_q <= ph_q[PAB-1 -: LAB];
      v1_q <= v0_q;
      i1_q <= i0_q;
      q1_q <= q0_q;
      c1_q <= cos_d;
      s1_q <= sin_d;
      v2_q <= v1_q;
      ic_q <= i1_q * c1_q;
      qs_q <= q1_q * s1_q;
      qc_q <= q1_q * c1_q;
      is_q <= i1_q * s1_q;
      v3_q <= v2_q;
      // Outputs hold between strobes
      if (v2_q) begin
        i3_q <= sat(re_sh);
        q3_q <= sat(im_sh);
      end
    end
  end

  assign bus.vld_out   = v3_q;
  assign bus.i_out     = i3_q;
  assign bus.q_out     = q3_q;
  assign bus.freq_word = fw_q;
  assign bus.phase     = ph_q;
  assign bus.loaded    = ld_q;
endmodule
